// File: rtl/i2s_rx_frontend.sv
// I2S receive front end: oversamples BCLK/LRCLK/SDATA in the clk_i domain and
// delivers one aligned left/right pair per audio frame with a single-cycle valid.
module i2s_rx_frontend #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  i2s_bclk_i,
    input  logic                  i2s_lrclk_i,
    input  logic                  i2s_sdata_i,
    output logic [DATA_WIDTH-1:0] left_o,
    output logic [DATA_WIDTH-1:0] right_o,
    output logic                  valid_o,
    output logic                  frame_err_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAD   = 2'd2;

    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
    logic                   bclk_d, bclk_rise, lr_smp, sd_smp;
    logic                   ws_prev, chan, left_ready;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-1:0]  shreg, left_hold, next_word;
    logic                   ws_change;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_d    <= 1'b0;
            bclk_rise <= 1'b0;
            lr_smp    <= 1'b0;
            sd_smp    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk_i};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk_i};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata_i};
            bclk_d    <= bclk_sync[SYNC_STAGES-1];
            // LRCLK/SDATA get one extra stage so they stay aligned with the registered strobe
            bclk_rise <= bclk_sync[SYNC_STAGES-1] & ~bclk_d;
            lr_smp    <= lr_sync[SYNC_STAGES-1];
            sd_smp    <= sd_sync[SYNC_STAGES-1];
        end
    end

    assign ws_change = bclk_rise && (lr_smp != ws_prev);
    assign next_word = {shreg[DATA_WIDTH-2:0], sd_smp};

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state       <= IDLE;
            ws_prev     <= 1'b0;
            chan        <= 1'b0;
            cnt         <= '0;
            shreg       <= '0;
            left_hold   <= '0;
            left_ready  <= 1'b0;
            left_o      <= '0;
            right_o     <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            if (bclk_rise) begin
                ws_prev <= lr_smp;
                case (state)
                    IDLE: begin
                        if (ws_change) begin
                            chan  <= lr_smp;
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (cnt == CNT_LAST) begin
                            shreg <= next_word;
                            if (!chan) begin
                                left_hold  <= next_word;
                                left_ready <= 1'b1;
                            end else if (left_ready) begin
                                left_o     <= left_hold;
                                right_o    <= next_word;
                                valid_o    <= 1'b1;
                                left_ready <= 1'b0;
                            end
                            // Exact-fit slot: the LSB edge is also the start of the next channel
                            if (ws_change) begin
                                chan  <= lr_smp;
                                cnt   <= '0;
                                state <= SHIFT;
                            end else begin
                                cnt   <= CNT_FULL;
                                state <= PAD;
                            end
                        end else if (ws_change) begin
                            frame_err_o <= 1'b1;
                            left_ready  <= 1'b0;
                            chan        <= lr_smp;
                            cnt         <= '0;
                        end else begin
                            shreg <= next_word;
                            cnt   <= cnt + CW'(1);
                        end
                    end
                    PAD: begin
                        if (ws_change) begin
                            chan  <= lr_smp;
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: drives I2S frames at several slot lengths
// and checks output pairs, valid/error pulse counts and reset behaviour.
`timescale 1ns/1ps
module tb_i2s_rx_frontend;

    localparam int DW   = 24;
    localparam int HALF = 163;

    logic          clk = 1'b0;
    logic          clr_i;
    logic          i2s_bclk_i, i2s_lrclk_i, i2s_sdata_i;
    logic [DW-1:0] left_o, right_o;
    logic          valid_o, frame_err_o;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0, e0;
    logic carry = 1'b0;

    i2s_rx_frontend #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .clr_i       (clr_i),
        .i2s_bclk_i  (i2s_bclk_i),
        .i2s_lrclk_i (i2s_lrclk_i),
        .i2s_sdata_i (i2s_sdata_i),
        .left_o      (left_o),
        .right_o     (right_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    // Counts clk cycles with each strobe high, so a stretched pulse shows up as extra counts
    always @(negedge clk) begin
        if (valid_o === 1'b1) valid_cnt++;
        if (frame_err_o === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic sd);
        i2s_lrclk_i = lr;
        i2s_sdata_i = sd;
        #HALF i2s_bclk_i = 1'b1;
        #HALF i2s_bclk_i = 1'b0;
    endtask

    // First bit of each slot carries the previous slot's tail; MSB follows on the next BCLK
    task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int len, input logic padv);
        logic [DW-1:0] sh;
        logic          b;
        sh = w;
        send_bit(ch, carry);
        for (int k = 1; k < len; k++) begin
            if (k <= DW) begin
                b  = sh[DW-1];
                sh = {sh[DW-2:0], 1'b0};
            end else begin
                b = padv;
            end
            send_bit(ch, b);
        end
        carry = (len > DW) ? padv : sh[DW-1];
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int len, input logic padv);
        send_slot(1'b0, l, len, padv);
        send_slot(1'b1, r, len, padv);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        clr_i       = 1'b1;
        i2s_bclk_i  = 1'b0;
        i2s_lrclk_i = 1'b0;
        i2s_sdata_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_left", 32'(left_o), 32'h0);
        chk("rst_right", 32'(right_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_err", 32'(frame_err_o), 32'h0);
        clr_i = 1'b0;
        repeat (4) @(negedge clk);

        // Nominal 64 fs; the first right word after reset has no left partner and is dropped
        frame(24'h123456, 24'hABCDEF, 32, 1'b0);
        settle();
        chk("lead_right_valid", 32'(valid_cnt), 32'd0);
        chk("lead_right_err", 32'(err_cnt), 32'd0);
        for (int f = 1; f <= 4; f++) begin
            frame(24'h123456, 24'hABCDEF, 32, 1'b0);
            settle();
            chk("nom_valid_cnt", 32'(valid_cnt), 32'(f));
            chk("nom_left", 32'(left_o), 32'h123456);
            chk("nom_right", 32'(right_o), 32'hABCDEF);
        end
        chk("nom_err", 32'(err_cnt), 32'd0);

        // Reset in the middle of a right slot
        send_slot(1'b0, 24'h123456, 32, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        clr_i = 1'b1;
        #1;
        chk("midrst_left", 32'(left_o), 32'h0);
        chk("midrst_right", 32'(right_o), 32'h0);
        chk("midrst_valid", 32'(valid_o), 32'h0);
        chk("midrst_err", 32'(frame_err_o), 32'h0);
        repeat (3) @(negedge clk);
        clr_i = 1'b0;
        v0 = valid_cnt;
        for (int i = 0; i < 22; i++) send_bit(1'b1, 1'b0);
        carry = 1'b0;
        settle();
        chk("midrst_tail_valid", 32'(valid_cnt - v0), 32'd0);
        send_slot(1'b0, 24'h55AA33, 32, 1'b0);
        settle();
        chk("midrst_left_valid", 32'(valid_cnt - v0), 32'd0);
        send_slot(1'b1, 24'h33CC11, 32, 1'b0);
        settle();
        chk("midrst_frame_valid", 32'(valid_cnt - v0), 32'd1);
        chk("midrst_frame_left", 32'(left_o), 32'h55AA33);
        chk("midrst_frame_right", 32'(right_o), 32'h33CC11);

        // Exact-fit 48 fs: each LSB rides the LRCLK transition edge
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int f = 0; f < 3; f++) frame(24'h800000, 24'h7FFFFF, 24, 1'b0);
        settle();
        chk("fit_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        chk("fit_left", 32'(left_o), 32'h800000);
        chk("fit_right", 32'(right_o), 32'h7FFFFF);
        chk("fit_err", 32'(err_cnt - e0), 32'd0);

        // 64 fs with all pad bits high; first left slot also closes the last exact-fit right word
        v0 = valid_cnt;
        for (int f = 0; f < 2; f++) frame(24'h000001, 24'hFFFFFE, 32, 1'b1);
        settle();
        chk("pad_valid_cnt", 32'(valid_cnt - v0), 32'd3);
        chk("pad_left", 32'(left_o), 32'h000001);
        chk("pad_right", 32'(right_o), 32'hFFFFFE);
        chk("pad_err", 32'(err_cnt - e0), 32'd0);

        // Short right slot after a good left word
        v0 = valid_cnt;
        e0 = err_cnt;
        send_slot(1'b0, 24'h111111, 32, 1'b0);
        send_slot(1'b1, 24'h222222, 16, 1'b0);
        send_slot(1'b0, 24'h0A0B0C, 32, 1'b0);
        settle();
        chk("short_err", 32'(err_cnt - e0), 32'd1);
        chk("short_valid", 32'(valid_cnt - v0), 32'd0);
        chk("short_hold_left", 32'(left_o), 32'h000001);
        chk("short_hold_right", 32'(right_o), 32'hFFFFFE);
        send_slot(1'b1, 24'h0D0E0F, 32, 1'b0);
        settle();
        chk("recover_valid", 32'(valid_cnt - v0), 32'd1);
        chk("recover_left", 32'(left_o), 32'h0A0B0C);
        chk("recover_right", 32'(right_o), 32'h0D0E0F);
        chk("recover_err", 32'(err_cnt - e0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
